serial_mod5_check_transmitter: RTL and testbench

//  Sender end of the serial divisible-by-5 link. Takes a W-bit word over valid/ready.

---
 rtl/serial_fsm_pkg.sv | 49 ++++
 rtl/serial_mod5_remainder.sv | 19 +
 rtl/serial_mod5_check_transmitter.sv | 119 +++++++++++
 tb/tb_serial_mod5_check_transmitter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/serial_fsm_pkg.sv
// Shared types and mod-5 helpers for the serial divisible-by-5 link.
// Used by serial_mod5_check_transmitter and serial_mod5_remainder.
package serial_fsm_pkg;

  localparam int CHECK_W = 3;

  typedef enum logic [2:0] {
    rem0 = 3'd0,
    rem1 = 3'd1,
    rem2 = 3'd2,
    rem3 = 3'd3,
    rem4 = 3'd4
  } rem_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    CHECK = 2'd2
  } tx_state_t;

  // Next remainder after appending bit b: (2*r + b) % 5.
  function automatic rem_t mod5_step(input rem_t r, input logic b);
    rem_t n;
    case (r)
      rem0:    n = b ? rem1 : rem0;
      rem1:    n = b ? rem3 : rem2;
      rem2:    n = b ? rem0 : rem4;
      rem3:    n = b ? rem2 : rem1;
      rem4:    n = b ? rem4 : rem3;
      default: n = rem0;
    endcase
    return n;
  endfunction

  // Three bits c such that (8*r + c) % 5 == 0.
  function automatic logic [CHECK_W-1:0] mod5_check(input rem_t r);
    logic [CHECK_W-1:0] c;
    case (r)
      rem0:    c = 3'b000;
      rem1:    c = 3'b010;
      rem2:    c = 3'b100;
      rem3:    c = 3'b001;
      rem4:    c = 3'b011;
      default: c = 3'b000;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/serial_mod5_remainder.sv
// Five-state remainder FSM: tracks the value of the bit stream seen so far, mod 5.
module serial_mod5_remainder
  import serial_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic bit_in,
  output rem_t rem
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        rem <= rem0;
    else if (clear)  rem <= rem0;
    else if (enable) rem <= mod5_step(rem, bit_in);
  end

endmodule

// File: rtl/serial_mod5_check_transmitter.sv
// Serial sender: W data bits MSB-first, then 3 check bits making the frame divisible by 5.
// The check field is compiled only when SERIAL_MOD5_TX_CHECK_EN is defined.
module serial_mod5_check_transmitter
  import serial_fsm_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         new_bit,
  output logic         bit_valid,
  output logic         frame_start,
  output logic         frame_end
);

  // Shift register is at least 3 bits wide so the check field always fits.
  localparam int SW = (W < CHECK_W) ? CHECK_W : W;
  localparam int CW = $clog2(W + CHECK_W);

  tx_state_t     r_state, w_next;
  logic [SW-1:0] r_shreg;
  logic [CW-1:0] r_cnt;
  logic          r_fs, r_fe;
  logic          w_hs, w_last, w_bit;

  assign w_hs   = in_valid && in_ready;
  assign w_last = (r_cnt == '0);
  assign w_bit  = r_shreg[SW-1];

`ifdef SERIAL_MOD5_TX_CHECK_EN
  rem_t               w_rem;
  logic [CHECK_W-1:0] w_chk;

  serial_mod5_remainder u_rem (
    .clk    (clk),
    .rst    (rst),
    .clear  (w_hs),
    .enable (r_state == DATA),
    .bit_in (w_bit),
    .rem    (w_rem)
  );

  // Fold in the bit leaving on this edge before choosing the check field.
  assign w_chk = mod5_check(mod5_step(w_rem, w_bit));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_hs) w_next = DATA;
`ifdef SERIAL_MOD5_TX_CHECK_EN
      DATA:  if (w_last) w_next = CHECK;
      CHECK: if (w_last) w_next = IDLE;
`else
      DATA:  if (w_last) w_next = IDLE;
`endif
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == IDLE);
    bit_valid   = (r_state != IDLE);
    new_bit     = w_bit;
    frame_start = r_fs;
    frame_end   = r_fe;
  end

  // Shifted-out positions fill with zero, so new_bit is 0 whenever idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_fs    <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_fs <= w_hs;
      r_fe <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_hs) begin
            r_shreg <= SW'(in_data) << (SW - W);
            r_cnt   <= CW'(W - 1);
          end
        end
        DATA: begin
          r_shreg <= r_shreg << 1;
          r_cnt   <= r_cnt - CW'(1);
`ifdef SERIAL_MOD5_TX_CHECK_EN
          if (w_last) begin
            r_shreg <= SW'(w_chk) << (SW - CHECK_W);
            r_cnt   <= CW'(CHECK_W - 1);
          end
`else
          if (r_cnt == CW'(1)) r_fe  <= 1'b1;
          if (w_last)          r_cnt <= '0;
`endif
        end
`ifdef SERIAL_MOD5_TX_CHECK_EN
        CHECK: begin
          r_shreg <= r_shreg << 1;
          r_cnt   <= w_last ? '0 : r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_fe <= 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mod5_check_transmitter.sv
// Scoreboard bench: each accepted word queues its expected frame, a negedge monitor
// rebuilds frames from the serial stream and checks value, length, framing and mod 5.
module tb_serial_mod5_check_transmitter;

  localparam int W = 16;
`ifdef SERIAL_MOD5_TX_CHECK_EN
  localparam int FL = W + 3;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         new_bit, bit_valid, frame_start, frame_end;

  serial_mod5_check_transmitter #(.W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .new_bit     (new_bit),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_end   (frame_end)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Expected frame as a number: data followed by the smallest c making it divisible by 5.
  function automatic logic [31:0] frame_val(input logic [W-1:0] d);
    logic [31:0] v;
    int          c;
    v = {16'h0, d};
`ifdef SERIAL_MOD5_TX_CHECK_EN
    c = (5 - int'((v * 8) % 5)) % 5;
    return (v << 3) | 32'(c);
`else
    c = 0;
    return v | 32'(c);
`endif
  endfunction

  logic [31:0] sb[$];

  // Monitor
  int          cyc = 0;
  int          nbits = 0;
  int          rx = 0;
  int          exp_start = -1;
  logic [31:0] acc = '0;
  logic [31:0] exp_v;
  bit          rdy_seen = 1'b0;
  bit          fs_bad = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      nbits = 0; acc = '0; rx = 0; rdy_seen = 1'b0; fs_bad = 1'b0; exp_start = -1;
    end else if (bit_valid) begin
      if (nbits == 0) begin
        chk("frame_start", frame_start, 1);
        if (exp_start >= 0) chk("idle_gap", cyc, exp_start);
        exp_start = -1;
      end else if (frame_start) fs_bad = 1'b1;
      if (in_ready) rdy_seen = 1'b1;
      acc = {acc[30:0], new_bit};
      rx  = (2 * rx + int'(new_bit)) % 5;
      nbits++;
      if (frame_end || nbits >= FL) begin
        chk("frame_len", nbits, FL);
        chk("frame_end", frame_end, 1);
        if (sb.size() == 0) chk("sb_underflow", sb.size(), 1);
        else begin
          exp_v = sb.pop_front();
          chk("frame_val", acc, exp_v);
        end
`ifdef SERIAL_MOD5_TX_CHECK_EN
        chk("div_by_5", rx, 0);
`endif
        chk("ready_low", rdy_seen, 0);
        chk("single_fs", fs_bad, 0);
        exp_start = in_valid ? cyc + 2 : -1;
        nbits = 0; acc = '0; rx = 0; rdy_seen = 1'b0; fs_bad = 1'b0;
      end
    end else if (nbits > 0) begin
      chk("frame_cut", nbits, FL);
      nbits = 0; acc = '0; rx = 0;
    end
  end

  // Called just after a rising edge; returns just after the handshake edge.
  task automatic send(input logic [W-1:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("accept", in_ready, 1);
    if (in_ready) sb.push_back(frame_val(d));
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = ~d;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 32'(n < 200), 1);
  endtask

  logic [W-1:0] rnd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_new_bit",  new_bit, 0);
    chk("rst_bit_valid", bit_valid, 0);
    chk("rst_fs", frame_start, 0);
    chk("rst_fe", frame_end, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(posedge clk); #1;

    send(16'h0001); drain();
    send(16'h0007); drain();
    send(16'hFFFF); drain();

    // Back-to-back words: only the idle cycle between frames may accept.
    send(16'hA5A5); send(16'h1234); send(16'h8000); drain();

    // Abort mid-frame, then a full frame must follow with a clean remainder.
    send(16'hFFF0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("abort_bit_valid", bit_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_fe", frame_end, 0);
    chk("abort_new_bit", new_bit, 0);
    sb.delete();
    @(negedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    send(16'h0001); drain();

    for (int i = 0; i < 1000; i++) begin
      rnd = W'($urandom);
      send(rnd);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
